tx_stream_engine: RTL and testbench

//  Parametrised UART result streamer between the dual operand memories and the UART TX.
//  On a one-hot command it reads N_ELEM element pairs (A[i], B[i]) and computes one byte
//  per element: A, B, A+B, avg, |A-B| or max. It sends each byte through the
//  tx_start/tx_busy handshake. A gap timer separates bytes. A command can be aborted.

---
 rtl/tx_stream_engine.sv | 181 ++++++++++++++++++
 tb/tb_tx_stream_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_stream_engine.sv
// tx_stream_engine: streams one computed byte per element pair to the UART TX.
// Ports:
//   clk, rst (async, active-low)
//   action[5:0]   one-hot command ([0]=A [1]=B [2]=SUM [3]=AVG [4]=DIFF [5]=ABORT,
//                 6'b110000 = MAX)
//   mem_a, mem_b  operands read at address_out (one-cycle read latency)
//   tx_busy       UART transmitting
//   tx_start      one-cycle start pulse to the UART
//   data_out      registered byte to transmit
//   address_out   element index
//   busy          command in progress
//   done          one-cycle pulse when a command ends (normal or aborted)
module tx_stream_engine #(
    parameter int DATA_W     = 8,
    parameter int N_ELEM     = 4,
    parameter int ADDR_W     = 10,
    parameter int GAP_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        action,
    input  logic [DATA_W-1:0] mem_a,
    input  logic [DATA_W-1:0] mem_b,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] address_out,
    output logic              busy,
    output logic              done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        START,
        WAIT_ACK,
        WAIT_TX
    } state_t;

    typedef enum logic [2:0] {
        M_A,
        M_B,
        M_SUM,
        M_AVG,
        M_DIFF,
        M_MAX
    } mode_t;

    state_t            state;
    mode_t             mode;
    logic [GAP_W-1:0]  gap_cnt;
    logic              abort_flag;

    logic              cmd_ok;
    mode_t             cmd_mode;
    logic              is_abort;
    logic [DATA_W:0]   sum_ext;
    logic              a_ge_b;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] result;

    assign is_abort = (action == 6'b100000);

    // Only exact command codes start a stream; MAX shares bit 4 with DIFF.
    always_comb begin
        cmd_ok   = 1'b1;
        cmd_mode = M_A;
        case (action)
            6'b000001: cmd_mode = M_A;
            6'b000010: cmd_mode = M_B;
            6'b000100: cmd_mode = M_SUM;
            6'b001000: cmd_mode = M_AVG;
            6'b010000: cmd_mode = M_DIFF;
            6'b110000: cmd_mode = M_MAX;
            default:   cmd_ok   = 1'b0;
        endcase
    end

    // The extra sum bit keeps the average exact for any operand pair.
    assign sum_ext = {1'b0, mem_a} + {1'b0, mem_b};
    assign a_ge_b  = (mem_a >= mem_b);
    assign diff    = a_ge_b ? (mem_a - mem_b) : (mem_b - mem_a);

    always_comb begin
        result = mem_a;
        case (mode)
            M_A:     result = mem_a;
            M_B:     result = mem_b;
            M_SUM:   result = sum_ext[DATA_W-1:0];
            M_AVG:   result = sum_ext[DATA_W:1];
            M_DIFF:  result = diff;
            M_MAX:   result = a_ge_b ? mem_a : mem_b;
            default: result = mem_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mode        <= M_A;
            gap_cnt     <= '0;
            abort_flag  <= 1'b0;
            tx_start    <= 1'b0;
            data_out    <= '0;
            address_out <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_ok) begin
                        mode        <= cmd_mode;
                        address_out <= '0;
                        busy        <= 1'b1;
                        gap_cnt     <= '0;
                        abort_flag  <= 1'b0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    if (is_abort) begin
                        state       <= IDLE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        address_out <= '0;
                        abort_flag  <= 1'b0;
                    end else if (gap_cnt == GAP_LAST) begin
                        // Memory data for address_out has settled by now.
                        data_out <= result;
                        tx_start <= 1'b1;
                        state    <= START;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                START: begin
                    if (is_abort) begin
                        abort_flag <= 1'b1;
                    end
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (is_abort) begin
                        abort_flag <= 1'b1;
                    end
                    if (tx_busy) begin
                        state <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (!tx_busy) begin
                        // An abort landing on the final edge still ends here.
                        if (address_out == LAST_ADDR || abort_flag || is_abort) begin
                            state       <= IDLE;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            address_out <= '0;
                            abort_flag  <= 1'b0;
                        end else begin
                            address_out <= address_out + ADDR_W'(1);
                            gap_cnt     <= '0;
                            state       <= GAP;
                        end
                    end else if (is_abort) begin
                        abort_flag <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_stream_engine.sv
// tb_tx_stream_engine: randomized bench with a transaction-level reference model
// of the streamer, a sync-memory emulator and a UART busy responder.
module tb_tx_stream_engine;

    localparam int DATA_W     = 8;
    localparam int N_ELEM     = 4;
    localparam int ADDR_W     = 10;
    localparam int GAP_CYCLES = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [5:0]        action = '0;
    logic [DATA_W-1:0] mem_a = '0;
    logic [DATA_W-1:0] mem_b = '0;
    logic              tx_busy = 1'b0;
    logic              tx_start;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] address_out;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    tx_stream_engine #(
        .DATA_W(DATA_W),
        .N_ELEM(N_ELEM),
        .ADDR_W(ADDR_W),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .action(action),
        .mem_a(mem_a),
        .mem_b(mem_b),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .data_out(data_out),
        .address_out(address_out),
        .busy(busy),
        .done(done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    logic [DATA_W-1:0] ma [N_ELEM];
    logic [DATA_W-1:0] mb [N_ELEM];
    bit         rand_mem = 1;
    bit         model_busy = 0;
    logic [5:0] model_mode = '0;
    int         n_sent = 0;
    bit         aborted = 0;
    int         acc_cyc = 0;
    int         last_fall = -1;
    bit         done_seen = 0;
    int         prev_addr = 0;
    int         cap[$];
    int         st[$];

    // UART responder
    int dly_cfg = 0;
    int hold_cfg = 0;
    int resp_wait = 0;
    int resp_hold = 0;

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, got, got, exp, exp, cyc);
        end
    endtask

    function automatic bit accepted(logic [5:0] a);
        return (a[5] == 1'b0 && $countones(a[4:0]) == 1) || a == 6'b110000;
    endfunction

    function automatic int exp_byte(logic [5:0] m, int a, int b);
        int mask;
        mask = (1 << DATA_W) - 1;
        case (m)
            6'b000001: return a;
            6'b000010: return b;
            6'b000100: return (a + b) & mask;
            6'b001000: return (a + b) / 2;
            6'b010000: return (a >= b) ? a - b : b - a;
            6'b110000: return (a >= b) ? a : b;
            default:   return -1;
        endcase
    endfunction

    task automatic drive(logic [5:0] a);
        action = a;
        if (!model_busy) begin
            if (accepted(a)) begin
                model_busy = 1;
                model_mode = a;
                n_sent = 0;
                aborted = 0;
                acc_cyc = cyc;
                last_fall = -1;
                done_seen = 0;
                cap.delete();
                st.delete();
                if (rand_mem) begin
                    for (int i = 0; i < N_ELEM; i++) begin
                        ma[i] = DATA_W'($urandom);
                        mb[i] = DATA_W'($urandom);
                    end
                end
            end
        end else if (a == 6'b100000) begin
            aborted = 1;
        end
    endtask

    // One clock: responder, memory, then every output compared to the model.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (resp_hold > 0) begin
            resp_hold--;
            if (resp_hold == 0) begin
                tx_busy = 1'b0;
                last_fall = cyc;
            end
        end else if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0) begin
                tx_busy = 1'b1;
                resp_hold = (hold_cfg > 0) ? hold_cfg : $urandom_range(1, 20);
            end
        end
        if (prev_addr < N_ELEM) begin
            mem_a = ma[prev_addr];
            mem_b = mb[prev_addr];
        end
        prev_addr = int'(address_out);
        chk("addr_range", int'(int'(address_out) < N_ELEM), 1);
        if (tx_start) begin
            chk("start_vs_txbusy", int'(tx_busy), 0);
            if (!model_busy || aborted) begin
                chk("unexpected_start", 1, 0);
            end else begin
                chk("addr", int'(address_out), n_sent);
                if (n_sent < N_ELEM)
                    chk("byte", int'(data_out),
                        exp_byte(model_mode, int'(ma[n_sent]), int'(mb[n_sent])));
                if (n_sent == 0)
                    chk("first_start_lat", cyc - acc_cyc, GAP_CYCLES + 1);
                else
                    chk("gap_after_busy", cyc - last_fall, GAP_CYCLES + 1);
            end
            cap.push_back(int'(data_out));
            st.push_back(cyc);
            n_sent++;
            resp_wait = (dly_cfg > 0) ? dly_cfg : $urandom_range(1, 4);
        end
        if (done) begin
            if (!model_busy) begin
                chk("spurious_done", 1, 0);
            end else begin
                chk("done_busy", int'(busy), 0);
                chk("done_addr", int'(address_out), 0);
                if (!aborted) begin
                    chk("done_count", n_sent, N_ELEM);
                    chk("done_lat", cyc - last_fall, 1);
                end else begin
                    chk("abort_count", int'(n_sent <= N_ELEM), 1);
                end
                model_busy = 0;
                done_seen = 1;
            end
        end else begin
            chk("busy", int'(busy), int'(model_busy));
        end
    endtask

    task automatic wait_done(int budget);
        int t;
        t = 0;
        while (!done_seen && t < budget) begin
            step();
            t++;
        end
        if (!done_seen) chk("done_timeout", 0, 1);
    endtask

    task automatic run_cmd(logic [5:0] a);
        drive(a);
        step();
        drive(6'b000000);
        wait_done(3000);
    endtask

    initial begin
        for (int i = 0; i < N_ELEM; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        step();
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_addr", int'(address_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b1;
        step();

        // pass-through A with a slow UART: fixed busy delay 3, hold 20
        rand_mem = 0;
        for (int i = 0; i < N_ELEM; i++) begin
            ma[i] = DATA_W'(8'h10 + i);
            mb[i] = DATA_W'($urandom);
        end
        dly_cfg = 3;
        hold_cfg = 20;
        run_cmd(6'b000001);
        chk("t1_nbytes", cap.size(), 4);
        for (int i = 0; i < 4 && i < cap.size(); i++)
            chk("t1_byte", cap[i], 8'h10 + i);
        if (st.size() >= 2)
            chk("t3_spacing", st[1] - st[0], 3 + 20 + GAP_CYCLES + 1);
        dly_cfg = 0;
        hold_cfg = 0;

        // arithmetic modes on A=F0, B=20
        for (int i = 0; i < N_ELEM; i++) begin
            ma[i] = 8'hF0;
            mb[i] = 8'h20;
        end
        run_cmd(6'b000100);
        chk("t2_sum", cap.size() > 0 ? cap[0] : -1, 8'h10);
        run_cmd(6'b001000);
        chk("t2_avg", cap.size() > 0 ? cap[0] : -1, 8'h88);
        run_cmd(6'b010000);
        chk("t2_diff", cap.size() > 0 ? cap[0] : -1, 8'hD0);
        run_cmd(6'b110000);
        chk("t2_max", cap.size() > 0 ? cap[0] : -1, 8'hF0);

        // abort during the first byte's UART transfer
        rand_mem = 1;
        drive(6'b000001);
        step();
        drive(6'b000000);
        for (int t = 0; t < 200 && !(n_sent == 1 && tx_busy && resp_hold > 1); t++)
            step();
        drive(6'b100000);
        step();
        drive(6'b000000);
        wait_done(200);
        chk("t4_nbytes", cap.size(), 1);

        // multi-hot ignored, then a command ignores a second command
        drive(6'b000011);
        step();
        drive(6'b000000);
        step();
        step();
        chk("t5_multihot_busy", int'(busy), 0);
        drive(6'b000100);
        step();
        drive(6'b000001);
        step();
        drive(6'b000000);
        wait_done(3000);
        chk("t5_nbytes", cap.size(), 4);

        // abort while idle does nothing
        drive(6'b100000);
        step();
        drive(6'b000000);
        for (int t = 0; t < 4; t++) step();

        // asynchronous reset in the middle of a transfer
        drive(6'b000010);
        step();
        drive(6'b000000);
        for (int t = 0; t < 200 && !(n_sent == 1 && tx_busy && resp_hold > 1); t++)
            step();
        #2 rst = 1'b0;
        #1;
        chk("t6_tx_start", int'(tx_start), 0);
        chk("t6_data_out", int'(data_out), 0);
        chk("t6_addr", int'(address_out), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        model_busy = 0;
        tx_busy = 1'b0;
        resp_wait = 0;
        resp_hold = 0;
        step();
        step();
        rst = 1'b1;
        step();
        run_cmd(6'b000001);
        chk("t6_restart_nbytes", cap.size(), 4);

        // randomized commands, junk actions and aborts
        for (int k = 0; k < 60; k++) begin
            logic [5:0] a;
            int abort_at;
            int t;
            case ($urandom_range(0, 9))
                0: a = 6'b000001;
                1: a = 6'b000010;
                2: a = 6'b000100;
                3: a = 6'b001000;
                4: a = 6'b010000;
                5: a = 6'b110000;
                6: a = 6'b000100;
                default: a = 6'($urandom_range(0, 63));
            endcase
            drive(a);
            step();
            if (model_busy) begin
                abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 80) : -1;
                t = 0;
                while (!done_seen && t < 3000) begin
                    if (t == abort_at)
                        drive(6'b100000);
                    else if ($urandom_range(0, 19) == 0)
                        drive(6'($urandom_range(0, 63)));
                    else
                        drive(6'b000000);
                    step();
                    t++;
                end
                if (!done_seen) chk("rand_timeout", 0, 1);
                drive(6'b000000);
            end else begin
                drive(6'b000000);
                step();
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
